// File: rtl/tlu_trigger_sequencer.sv
// rtl/tlu_trigger_sequencer.sv - TLU trigger sequencer: timestamp, readout start/timeout, event header stream
module tlu_trigger_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        CLK,
  input  logic        RST_SYS,
  input  logic        ENABLE,
  input  logic        TRIG_VALID,
  input  logic        TRIG_CNT_VALID,
  input  logic [15:0] TRIG_CNT,
  output logic        RO_START,
  input  logic        RO_DONE,
  output logic        DAQ_BUSY,
  output logic [63:0] HDR_DATA,
  output logic        HDR_VALID,
  input  logic        HDR_READY,
  output logic [31:0] EVT_COUNT,
  output logic [15:0] ERR_COUNT
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_CNT, S_START, S_READOUT, S_EMIT} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_ts;
  logic [31:0] r_ts_lat;
  logic [15:0] r_num_lat;
  logic [15:0] r_last_num;
  logic [15:0] r_to_cnt;
  logic        r_first;
  logic        r_enable;
  logic        r_ro_start;
  logic        r_hdr_valid;
  logic [63:0] r_hdr_data;
  logic [31:0] r_evt_count;
  logic [15:0] r_err_count;
  logic        w_timeout_hit;
  logic        w_accept;
  logic        w_mismatch;

  assign w_timeout_hit = (r_to_cnt == TO_LAST);
  assign w_accept      = r_hdr_valid && HDR_READY;
  assign w_mismatch    = !r_first && (r_num_lat != r_last_num + 16'd1);

  always_ff @(posedge CLK or posedge RST_SYS) begin
    if (RST_SYS) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (ENABLE && TRIG_VALID) w_next = S_WAIT_CNT;
      S_WAIT_CNT: begin
        if (TRIG_CNT_VALID)   w_next = S_START;
        else if (!TRIG_VALID) w_next = S_IDLE;
      end
      S_START:    w_next = S_READOUT;
      S_READOUT:  if (RO_DONE || w_timeout_hit) w_next = S_EMIT;
      S_EMIT:     if (w_accept) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST_SYS) begin
    if (RST_SYS) begin
      r_ts        <= '0;
      r_ts_lat    <= '0;
      r_num_lat   <= '0;
      r_last_num  <= '0;
      r_to_cnt    <= '0;
      r_first     <= 1'b1;
      r_enable    <= 1'b0;
      r_ro_start  <= 1'b0;
      r_hdr_valid <= 1'b0;
      r_hdr_data  <= '0;
      r_evt_count <= '0;
      r_err_count <= '0;
    end else begin
      r_ts       <= r_ts + 32'd1;
      r_enable   <= ENABLE;
      r_ro_start <= (r_state == S_START);

      if (r_state == S_IDLE && w_next == S_WAIT_CNT) r_ts_lat <= r_ts;
      if (r_state == S_WAIT_CNT && TRIG_CNT_VALID)   r_num_lat <= TRIG_CNT;

      if (r_state == S_START)        r_to_cnt <= '0;
      else if (r_state == S_READOUT) r_to_cnt <= r_to_cnt + 16'd1;

      // Leaving READOUT without RO_DONE can only mean the timeout expired.
      if (r_state == S_READOUT && w_next == S_EMIT) begin
        r_hdr_valid <= 1'b1;
        r_hdr_data  <= {r_num_lat, r_ts_lat, 13'd0, r_first, !RO_DONE, w_mismatch};
      end else if (w_accept) begin
        r_hdr_valid <= 1'b0;
      end

      if (w_accept) begin
        r_evt_count <= r_evt_count + 32'd1;
        r_last_num  <= r_hdr_data[63:48];
        if ((r_hdr_data[1] || r_hdr_data[0]) && r_err_count != 16'hFFFF)
          r_err_count <= r_err_count + 16'd1;
      end

      if (ENABLE && !r_enable) r_first <= 1'b1;
      else if (w_accept)       r_first <= 1'b0;
    end
  end

  assign RO_START  = r_ro_start;
  assign HDR_VALID = r_hdr_valid;
  assign HDR_DATA  = r_hdr_data;
  assign EVT_COUNT = r_evt_count;
  assign ERR_COUNT = r_err_count;
  assign DAQ_BUSY  = !r_enable || (r_state != S_IDLE);

endmodule

// File: tb/tb_tlu_trigger_sequencer.sv
// tb/tb_tlu_trigger_sequencer.sv - scoreboard bench for tlu_trigger_sequencer
module tb_tlu_trigger_sequencer;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        RST_SYS;
  logic        ENABLE;
  logic        TRIG_VALID;
  logic        TRIG_CNT_VALID;
  logic [15:0] TRIG_CNT;
  logic        RO_START;
  logic        RO_DONE;
  logic        DAQ_BUSY;
  logic [63:0] HDR_DATA;
  logic        HDR_VALID;
  logic        HDR_READY;
  logic [31:0] EVT_COUNT;
  logic [15:0] ERR_COUNT;

  int          checks   = 0;
  int          failures = 0;
  int          ro_pulses = 0;
  logic [31:0] m_ts;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  tlu_trigger_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(clk), .RST_SYS(RST_SYS), .ENABLE(ENABLE),
    .TRIG_VALID(TRIG_VALID), .TRIG_CNT_VALID(TRIG_CNT_VALID), .TRIG_CNT(TRIG_CNT),
    .RO_START(RO_START), .RO_DONE(RO_DONE), .DAQ_BUSY(DAQ_BUSY),
    .HDR_DATA(HDR_DATA), .HDR_VALID(HDR_VALID), .HDR_READY(HDR_READY),
    .EVT_COUNT(EVT_COUNT), .ERR_COUNT(ERR_COUNT)
  );

  // Reference timestamp: free-running from reset release.
  always @(posedge clk or posedge RST_SYS) begin
    if (RST_SYS) m_ts <= '0;
    else         m_ts <= m_ts + 32'd1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (RO_START) ro_pulses++;
    if (!RST_SYS && HDR_VALID && HDR_READY) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL hdr_unexpected actual=%h expected=none", HDR_DATA);
      end else begin
        chk("hdr_data", HDR_DATA, exp_q.pop_front());
      end
    end
  end

  task automatic start_trig(input logic [15:0] num, input logic [2:0] flags);
    exp_q.push_back({num, m_ts, 13'd0, flags});
    TRIG_VALID = 1'b1;
    @(negedge clk);
    chk("busy_wait_cnt", DAQ_BUSY, 1'b1);
    TRIG_CNT = num;
    TRIG_CNT_VALID = 1'b1;
    @(negedge clk);
    TRIG_CNT_VALID = 1'b0;
    TRIG_VALID = 1'b0;
    @(negedge clk);
    chk("ro_start_latency", RO_START, 1'b1);
  endtask

  task automatic finish_trig(input int done_after, input int hold);
    int n = 0;
    int bad = 0;
    int exp_lat;
    logic [63:0] snap;
    logic [31:0] ev0;
    exp_lat = (done_after < 0) ? TO : done_after + 1;
    while (!HDR_VALID && n < 200) begin
      RO_DONE = (n == done_after);
      @(negedge clk);
      n++;
    end
    RO_DONE = 1'b0;
    chk("hdr_latency", n, exp_lat);
    if (hold > 0) begin
      snap = HDR_DATA;
      ev0  = EVT_COUNT;
      for (int i = 0; i < hold; i++) begin
        TRIG_VALID = (i == 5);
        if (!HDR_VALID || HDR_DATA !== snap || !DAQ_BUSY) bad++;
        @(negedge clk);
      end
      TRIG_VALID = 1'b0;
      chk("bp_stable", bad, 0);
      chk("bp_no_accept", EVT_COUNT, ev0);
      @(posedge clk);
      #1 HDR_READY = 1'b1;
      @(negedge clk);
      @(negedge clk);
    end else begin
      @(negedge clk);
    end
    chk("busy_after_accept", DAQ_BUSY, 1'b0);
  endtask

  task automatic do_trig(input logic [15:0] num, input logic [2:0] flags, input int done_after);
    int p0;
    p0 = ro_pulses;
    start_trig(num, flags);
    finish_trig(done_after, 0);
    chk("ro_start_once", ro_pulses - p0, 1);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_ro_start"}, RO_START, 1'b0);
    chk({tag, "_hdr_valid"}, HDR_VALID, 1'b0);
    chk({tag, "_busy"}, DAQ_BUSY, 1'b1);
    chk({tag, "_hdr_data"}, HDR_DATA, 64'd0);
    chk({tag, "_evt"}, EVT_COUNT, 32'd0);
    chk({tag, "_err"}, ERR_COUNT, 16'd0);
  endtask

  initial begin
    int p0;
    logic [31:0] ev0;
    RST_SYS = 1'b1; ENABLE = 1'b0; TRIG_VALID = 1'b0; TRIG_CNT_VALID = 1'b0;
    TRIG_CNT = '0; RO_DONE = 1'b0; HDR_READY = 1'b1;
    repeat (3) @(negedge clk);
    reset_vals("reset");
    RST_SYS = 1'b0;
    ENABLE = 1'b1;
    repeat (2) @(negedge clk);
    chk("busy_enabled_idle", DAQ_BUSY, 1'b0);

    // Nominal
    do_trig(16'h0005, 3'b100, 10);
    chk("nom_evt", EVT_COUNT, 32'd1);
    chk("nom_err", ERR_COUNT, 16'd0);

    // Aborted handshake
    p0 = ro_pulses; ev0 = EVT_COUNT;
    TRIG_VALID = 1'b1;
    @(negedge clk);
    TRIG_VALID = 1'b0;
    @(negedge clk);
    chk("abort_idle", DAQ_BUSY, 1'b0);
    repeat (4) @(negedge clk);
    chk("abort_no_ro", ro_pulses - p0, 0);
    chk("abort_no_evt", EVT_COUNT, ev0);

    // Disabled: triggers ignored
    ENABLE = 1'b0;
    @(negedge clk);
    chk("disabled_busy", DAQ_BUSY, 1'b1);
    TRIG_VALID = 1'b1;
    @(negedge clk);
    TRIG_CNT = 16'h1234; TRIG_CNT_VALID = 1'b1;
    @(negedge clk);
    TRIG_CNT_VALID = 1'b0; TRIG_VALID = 1'b0;
    repeat (4) @(negedge clk);
    chk("disabled_no_ro", ro_pulses - p0, 0);
    chk("disabled_no_evt", EVT_COUNT, ev0);
    ENABLE = 1'b1;
    repeat (2) @(negedge clk);
    chk("reenable_idle", DAQ_BUSY, 1'b0);

    // Continuity and wrap after re-enable
    do_trig(16'hFFFE, 3'b100, 2);
    do_trig(16'hFFFF, 3'b000, 0);
    do_trig(16'h0000, 3'b000, 5);
    do_trig(16'h0002, 3'b001, 1);
    chk("cont_err", ERR_COUNT, 16'd1);
    chk("cont_evt", EVT_COUNT, 32'd5);

    // Timeout
    do_trig(16'h0003, 3'b010, -1);
    chk("to_err", ERR_COUNT, 16'd2);

    // Backpressure with a stray trigger while a header is pending
    ev0 = EVT_COUNT;
    HDR_READY = 1'b0;
    start_trig(16'h0004, 3'b000);
    finish_trig(3, 20);
    chk("bp_evt_once", EVT_COUNT, ev0 + 32'd1);
    chk("bp_err", ERR_COUNT, 16'd2);

    // Reset mid-readout discards the pending header
    start_trig(16'h0009, 3'b000);
    repeat (3) @(negedge clk);
    RST_SYS = 1'b1;
    #1;
    reset_vals("midrst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    RST_SYS = 1'b0;
    repeat (2) @(negedge clk);
    do_trig(16'h0042, 3'b100, 2);
    chk("post_rst_evt", EVT_COUNT, 32'd1);
    chk("post_rst_err", ERR_COUNT, 16'd0);

    repeat (3) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tlu_trigger_sequencer.md
# tlu_trigger_sequencer

Sequences readout around each TLU trigger handshake. Watches the TLU handshake outputs (valid window, trigger-number strobe, 16-bit trigger number) and timestamps each trigger. It then starts a detector readout, extends BUSY until readout completes or times out, and emits one 64-bit event header per trigger on a valid/ready stream for the Ethernet packetiser. It sits between the TLU handshake block and the DAQ/packet path, in the CLK domain.

## Interface
- TIMEOUT_CYCLES, 4096: maximum cycles in READOUT before forced completion; legal range 2..65535.
- CLK  in  1  system clock, same clock as the TLU handshake block.
- RST_SYS  in  1  reset, asynchronous, active-high.
- ENABLE  in  1  run enable; level, synchronous.
- TRIG_VALID  in  1  high while the TLU handshake is in progress.
- TRIG_CNT_VALID  in  1  one-cycle strobe; TRIG_CNT is valid this cycle.
- TRIG_CNT  in  16  trigger number from the TLU.
- RO_START  out  1  one-cycle pulse to the detector readout.
- RO_DONE  in  1  readout complete; level or pulse, sampled in READOUT only.
- DAQ_BUSY  out  1  ORed into TLU BUSY at top level.
- HDR_DATA  out  64  event header.
- HDR_VALID  out  1  header valid.
- HDR_READY  in  1  downstream accept.
- EVT_COUNT  out  32  headers accepted since reset.
- ERR_COUNT  out  16  headers carrying mismatch or timeout, saturating at 16'hFFFF.

## Operation
- Free-running 32-bit timestamp counter `ts`. Reset to 0, increments every cycle, wraps 2^32-1 -> 0.
- States: IDLE, WAIT_CNT, START, READOUT, EMIT.
- IDLE: if ENABLE && TRIG_VALID, latch `ts` into `ts_lat` and go to WAIT_CNT. TRIG_VALID while !ENABLE is ignored.
- WAIT_CNT: on TRIG_CNT_VALID, latch TRIG_CNT into `num_lat` and go to START. If TRIG_VALID falls with no strobe, return to IDLE and emit no header.
- START: assert RO_START for exactly one cycle, clear the timeout counter, go to READOUT.
- READOUT:
  - On RO_DONE, go to EMIT with timeout flag = 0.
  - Otherwise the counter increments each cycle. When it reaches TIMEOUT_CYCLES-1 with no RO_DONE, go to EMIT with timeout flag = 1.
  - RO_DONE on the final counted cycle takes priority: timeout flag = 0.
- Header layout:
  - HDR_DATA[63:48] = `num_lat`.
  - HDR_DATA[47:16] = `ts_lat`.
  - HDR_DATA[15:3] = 0.
  - HDR_DATA[2] = first.
  - HDR_DATA[1] = timeout.
  - HDR_DATA[0] = mismatch.
- Continuity check: register `last_num`.
  - `first` = 1 for the first header after reset or after an ENABLE 0->1 transition; mismatch is then forced to 0.
  - Otherwise mismatch = (`num_lat` != `last_num` + 1 mod 2^16); 16'hFFFF -> 16'h0000 is legal.
  - `last_num` and `first` update when the header is accepted.
- EMIT:
  - Hold HDR_VALID and a stable HDR_DATA until HDR_READY.
  - On HDR_VALID && HDR_READY: EVT_COUNT += 1 (wraps); ERR_COUNT += 1 if flag[1] or flag[0] (saturating); go to IDLE.
- DAQ_BUSY = !ENABLE || state != IDLE. DAQ_BUSY stays high through EMIT backpressure, so no trigger is accepted while a header is pending.
- ENABLE falling mid-sequence does not abort. The sequence completes, including its header, then the block stays in IDLE.

## Timing
- Reset values:
  - State IDLE.
  - RO_START, HDR_VALID = 0.
  - DAQ_BUSY = 1 (ENABLE is effectively low during reset).
  - HDR_DATA, EVT_COUNT, ERR_COUNT, `ts`, `last_num` = 0.
  - `first` = 1.
- All outputs are registered except DAQ_BUSY, which is decoded from registered state and a registered ENABLE.
- DAQ_BUSY rises on the cycle after TRIG_VALID is sampled high in IDLE.
- RO_START asserts 2 cycles after TRIG_CNT_VALID is sampled.
- HDR_VALID asserts 1 cycle after RO_DONE is sampled in READOUT, or after timeout expiry.
- Return to IDLE, and DAQ_BUSY low, occurs 1 cycle after the accepting handshake.
- Minimum trigger-to-trigger: TRIG_VALID in IDLE -> IDLE again is 5 cycles plus the readout duration, with HDR_READY tied high.
- RST_SYS asserted mid-sequence drops all outputs to reset values asynchronously. Any pending header is discarded.

## Test plan
- Nominal: ENABLE=1, TRIG_CNT=16'h0005, RO_DONE 10 cycles after RO_START, HDR_READY=1 -> one RO_START pulse; HDR_DATA[63:48]=0005, flags=3'b100; EVT_COUNT=1; ERR_COUNT=0.
- Continuity and wrap: triggers FFFE, FFFF, 0000, then 0002 -> flags 100, 000, 000, then 001; ERR_COUNT=1; timestamps strictly increasing.
- Timeout: TIMEOUT_CYCLES=16, RO_DONE never asserted -> HDR_VALID exactly 16 cycles after RO_START; flag[1]=1; ERR_COUNT increments.
- Backpressure: HDR_READY low 20 cycles -> HDR_VALID and HDR_DATA stable and DAQ_BUSY high throughout; a TRIG_VALID pulse in that window produces no extra header; EVT_COUNT increments once.
- Aborted handshake and disable: TRIG_VALID falls without TRIG_CNT_VALID -> no RO_START, no header, IDLE. ENABLE=0 -> DAQ_BUSY=1 and triggers are ignored. Re-enable -> next header has flag[2]=1.
- Reset mid-READOUT: assert RST_SYS -> all outputs immediately at reset values; after release the next header has first=1 and EVT_COUNT=1.
